// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding selects,
// freeze FSM states and the architectural PC register index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_t;

  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding comparator for one EX operand: picks the youngest in-flight
// producer (M before W), never forwarding onto the PC register.
module fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              en,
  input  logic [REG_AW-1:0] ra_e,
  input  logic [REG_AW-1:0] wa_m,
  input  logic [REG_AW-1:0] wa_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output fwd_sel_t          fwd_sel
);

  // Operand source selection, M stage wins over W stage
  always_comb begin
    fwd_sel = FWD_RF;
    if (!en || (ra_e == REG_AW'(PC_REG))) begin
      fwd_sel = FWD_RF;
    end else if (reg_write_m && (ra_e == wa_m)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (ra_e == wa_w)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the F/D/E/M/W pipeline, with a memory
// freeze FSM, a sticky watchdog timeout and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] wa3E,
  input  logic [REG_AW-1:0] wa3M,
  input  logic [REG_AW-1:0] wa3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              mem_ready,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t          state_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               mem_timeout_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               mem_stall_s;
  logic               ldr_stall_s;
  logic               any_stall_s;
  fwd_sel_t           fwd_a_s;
  fwd_sel_t           fwd_b_s;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .en          (!rst),
    .ra_e        (ra1E),
    .wa_m        (wa3M),
    .wa_w        (wa3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_a_s)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .en          (!rst),
    .ra_e        (ra2E),
    .wa_m        (wa3M),
    .wa_w        (wa3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_b_s)
  );

  assign ForwardAE   = fwd_a_s;
  assign ForwardBE   = fwd_b_s;
  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;

  // Hazard detection: memory freeze depends on FSM state, load-use on E/D regs
  always_comb begin
    mem_stall_s = 1'b0;
    case (state_r)
      RUN:      mem_stall_s = MemReqM && !mem_ready;
      MEM_WAIT: mem_stall_s = !mem_ready;
      TIMEOUT:  mem_stall_s = 1'b1;
      default:  mem_stall_s = 1'b0;
    endcase
    ldr_stall_s = MemtoRegE && ((ra1D == wa3E) || (ra2D == wa3E));
  end

  // Prioritised stall/flush: freeze > branch flush > load-use bubble
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else if (mem_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (ldr_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
  end

  assign any_stall_s = StallF | StallD | StallE | StallM;

  // Memory freeze FSM with watchdog; TIMEOUT only leaves through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (MemReqM && !mem_ready) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1'b1);
          end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
            state_r       <= TIMEOUT;
            mem_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
          end
        end
        TIMEOUT: begin
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of cycles with any stage held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (any_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W). It produces the stall, flush and forwarding controls for the inter-stage segment registers and the EX operand muxes. It also runs a small FSM that freezes the pipeline while data memory is not ready, with a watchdog timeout. The segment registers capture on negedge clk; this block updates its state on posedge clk, so its combinational outputs settle within half a cycle.

Parameters:
REG_AW, 4, register-address width (16 architectural registers, R15 = PC)
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before the sticky timeout
CNT_W, 16, width of the saturating stall performance counter

Ports:
clk  in  1  clock; state updates on posedge
rst  in  1  asynchronous, active-high reset
ra1D, ra2D  in  REG_AW  source registers of the instruction in D
ra1E, ra2E  in  REG_AW  source registers of the instruction in E
wa3E, wa3M, wa3W  in  REG_AW  destination registers in E/M/W
RegWriteM, RegWriteW  in  1  register-write enables in M/W
MemtoRegE  in  1  instruction in E is a load
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  load or store active in M
mem_ready  in  1  data memory completes the M access this cycle
ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM  out  1  hold the PC / segment register
FlushD, FlushE  out  1  clear D/E segment register (bubble)
mem_timeout  out  1  sticky watchdog error
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst=1):
  - FSM state = RUN, wait_cnt = 0, mem_timeout = 0, stall_cnt = 0.
  - All Stall*/Flush* = 0 and ForwardAE/ForwardBE = 00 while rst is high.
- Forwarding (combinational, independent of the FSM):
  - ForwardAE = 10 if RegWriteM && ra1E==wa3M && ra1E!=15.
  - Else ForwardAE = 01 if RegWriteW && ra1E==wa3W && ra1E!=15.
  - Else ForwardAE = 00.
  - M wins when M and W target the same register. ForwardBE follows the same rule using ra2E.
- Load-use hazard: ldr_stall = MemtoRegE && (ra1D==wa3E || ra2D==wa3E). Asserts StallF, StallD and FlushE; inserts exactly 1 bubble.
- Branch: BranchTakenE asserts FlushD and FlushE for that cycle.
- Memory freeze: mem_stall = (state==RUN && MemReqM && !mem_ready) || state==MEM_WAIT&&!mem_ready || state==TIMEOUT. Asserts StallF, StallD, StallE, StallM.
- Priority (highest first):
  1. mem_stall: freeze only; Flush* = 0 and ldr/branch effects are suppressed.
  2. BranchTakenE: flush; StallF/StallD = 0 even if ldr_stall is active.
  3. ldr_stall.
- FSM (posedge clk):
  - RUN -> MEM_WAIT when MemReqM && !mem_ready; wait_cnt <= 1.
  - MEM_WAIT -> RUN when mem_ready; wait_cnt <= 0. In that same cycle the stalls deassert combinationally.
  - MEM_WAIT, !mem_ready: wait_cnt++. When wait_cnt == MEM_TIMEOUT -> TIMEOUT.
  - TIMEOUT: mem_timeout = 1. The pipeline stays frozen until rst; there is no other exit. mem_ready is ignored.
  - An illegal state encoding returns to RUN.
- stall_cnt: +1 on every posedge where any Stall* is 1. Saturates at 2^CNT_W-1 with no wrap.
- Reset mid-MEM_WAIT: immediately returns to RUN and all outputs drop to 0. The pending memory access is abandoned.

Decomposition:
- Package pipeline_pkg holds:
  - typedef fwd_sel_t (FWD_RF=00, FWD_WB=01, FWD_MEM=10)
  - typedef hz_state_t (RUN, MEM_WAIT, TIMEOUT)
  - constant PC_REG = 4'hF
- One natural sub-module, fwd_unit: the combinational forwarding comparator, instantiated once per operand (A, B).

Test Plan:
- Forwarding: RegWriteM=1, wa3M=3, ra1E=3; RegWriteW=1, wa3W=3 -> ForwardAE=10. Drop RegWriteM -> 01. Set ra1E=15 -> 00.
- Load-use: MemtoRegE=1, wa3E=5, ra2D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle, with MemtoRegE=0, all return to 0. stall_cnt=1.
- Branch over load-use: BranchTakenE=1 together with the previous ldr condition -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, mem_ready=0 for 3 cycles, then 1 -> Stall{F,D,E,M}=1 for 3 cycles, deasserted in the ready cycle, FSM back in RUN. stall_cnt=3.
- Timeout: MemReqM=1, mem_ready=0 held for 20 cycles -> after MEM_TIMEOUT=15 wait cycles, mem_timeout=1 and the stalls remain 1 even when mem_ready later rises. Asserting rst clears everything.
- Reset in MEM_WAIT: assert rst between clock edges -> all outputs 0 immediately (async). After release, state is RUN and stall_cnt=0.
